// File: rtl/param_counter.sv
// ----------------------------------------------------------------------------
// param_counter
//   Parametrised up/down counter with a range of 0..MAX_VALUE, an enable
//   prescaler, synchronous clear and parallel load, and a choice of wrap or
//   saturate behaviour at the range ends.
//
// Parameters
//   WIDTH     : bit width of CounterValue / LoadValue (1..32)
//   MAX_VALUE : highest count value (1..2**WIDTH-1)
//   PRESCALE  : enabled cycles per count step (1..65535)
//   SATURATE  : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   Clock         : system clock, rising edge
//   Reset         : asynchronous active-low reset
//   Enable        : count enable, advances the prescaler
//   Up            : 1 = increment, 0 = decrement
//   Clear         : synchronous clear to 0 (highest priority)
//   Load          : synchronous parallel load of LoadValue (clamped)
//   LoadValue     : value for Load
//   CounterValue  : registered current count
//   TerminalCount : combinational, count sits at the end of the range in the
//                   current direction
//   Wrapped       : registered one-cycle pulse after a wrap/saturate step
// ----------------------------------------------------------------------------
module param_counter #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  MAX_VALUE = '1,
  parameter int unsigned       PRESCALE  = 1,
  parameter bit                SATURATE  = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] CounterValue,
  output logic             TerminalCount,
  output logic             Wrapped
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  prescale_cnt;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    step          = Enable && (prescale_cnt == PS_LAST);
    // End of range in the direction currently selected on Up.
    boundary      = Up ? (CounterValue == MAX_VALUE) : (CounterValue == '0);
    TerminalCount = boundary;
    load_clamped  = (LoadValue > MAX_VALUE) ? MAX_VALUE : LoadValue;
    if (boundary) begin
      if (SATURATE)
        next_count = CounterValue;
      else
        next_count = Up ? '0 : MAX_VALUE;
    end else begin
      next_count = Up ? CounterValue + 1'b1 : CounterValue - 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      CounterValue <= '0;
      prescale_cnt <= '0;
      Wrapped      <= 1'b0;
    end else if (Clear) begin
      CounterValue <= '0;
      prescale_cnt <= '0;
      Wrapped      <= 1'b0;
    end else if (Load) begin
      CounterValue <= load_clamped;
      prescale_cnt <= '0;
      Wrapped      <= 1'b0;
    end else if (Enable) begin
      prescale_cnt <= step ? '0 : prescale_cnt + 1'b1;
      if (step)
        CounterValue <= next_count;
      Wrapped <= step && boundary;
    end else begin
      Wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// ----------------------------------------------------------------------------
// tb_param_counter
//   Five param_counter instances with different configurations share one set
//   of stimulus. Each instance is mirrored by an arithmetic reference model;
//   every clock edge compares all instances against their models. Directed
//   scenarios are listed in a vector table with hand-derived expectations.
// ----------------------------------------------------------------------------
module tb_param_counter;

  localparam int N = 5;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Up;
  logic       Clear;
  logic       Load;
  logic [7:0] LoadValue;

  logic [7:0] cv [N];
  logic [3:0] cv4;
  logic       tc [N];
  logic       wr [N];

  assign cv[4] = {4'b0000, cv4};

  // Per-instance configuration, mirrored by the models.
  int cmax  [N] = '{255, 9, 9, 9, 15};
  int cpre  [N] = '{1, 1, 1, 4, 3};
  bit csat  [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int cmask [N] = '{255, 255, 255, 255, 15};

  param_counter u0 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Clear(Clear),
    .Load(Load), .LoadValue(LoadValue), .CounterValue(cv[0]),
    .TerminalCount(tc[0]), .Wrapped(wr[0]));

  param_counter #(.WIDTH(8), .MAX_VALUE(8'd9), .PRESCALE(1), .SATURATE(1'b0)) u1 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Clear(Clear),
    .Load(Load), .LoadValue(LoadValue), .CounterValue(cv[1]),
    .TerminalCount(tc[1]), .Wrapped(wr[1]));

  param_counter #(.WIDTH(8), .MAX_VALUE(8'd9), .PRESCALE(1), .SATURATE(1'b1)) u2 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Clear(Clear),
    .Load(Load), .LoadValue(LoadValue), .CounterValue(cv[2]),
    .TerminalCount(tc[2]), .Wrapped(wr[2]));

  param_counter #(.WIDTH(8), .MAX_VALUE(8'd9), .PRESCALE(4), .SATURATE(1'b0)) u3 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Clear(Clear),
    .Load(Load), .LoadValue(LoadValue), .CounterValue(cv[3]),
    .TerminalCount(tc[3]), .Wrapped(wr[3]));

  param_counter #(.WIDTH(4), .MAX_VALUE(4'd15), .PRESCALE(3), .SATURATE(1'b1)) u4 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Clear(Clear),
    .Load(Load), .LoadValue(LoadValue[3:0]), .CounterValue(cv4),
    .TerminalCount(tc[4]), .Wrapped(wr[4]));

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int mcnt [N];
  int mps  [N];
  bit mwr  [N];

  typedef struct {
    bit         clr;
    bit         ld;
    bit         en;
    bit         up;
    logic [7:0] lv;
    int         inst;
    int         ecnt;
    bit         ewr;
    bit         etc;
  } vec_t;

  vec_t vt [$];

  function automatic void add(bit clr, bit ld, bit en, bit up, logic [7:0] lv,
                              int inst, int ecnt, bit ewr, bit etc);
    vt.push_back('{clr, ld, en, up, lv, inst, ecnt, ewr, etc});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      mps[i]  = 0;
      mwr[i]  = 1'b0;
    end
  endtask

  // One rising edge of the specified behaviour, computed arithmetically.
  task automatic model_edge();
    int v;
    bit stepped;
    if (!Reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (Clear) begin
        mcnt[i] = 0; mps[i] = 0; mwr[i] = 1'b0;
      end else if (Load) begin
        v       = int'(LoadValue) & cmask[i];
        mcnt[i] = (v > cmax[i]) ? cmax[i] : v;
        mps[i]  = 0;
        mwr[i]  = 1'b0;
      end else if (Enable) begin
        mps[i]  = (mps[i] + 1) % cpre[i];
        stepped = (mps[i] == 0);
        mwr[i]  = 1'b0;
        if (stepped && Up) begin
          mwr[i]  = (mcnt[i] == cmax[i]);
          mcnt[i] = csat[i] ? ((mcnt[i] + 1 > cmax[i]) ? cmax[i] : mcnt[i] + 1)
                            : (mcnt[i] + 1) % (cmax[i] + 1);
        end else if (stepped) begin
          mwr[i]  = (mcnt[i] == 0);
          mcnt[i] = csat[i] ? ((mcnt[i] - 1 < 0) ? 0 : mcnt[i] - 1)
                            : (mcnt[i] + cmax[i]) % (cmax[i] + 1);
        end
      end else begin
        mwr[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int etc;
    for (int i = 0; i < N; i++) begin
      etc = Up ? int'(mcnt[i] == cmax[i]) : int'(mcnt[i] == 0);
      chk($sformatf("%s_cnt_u%0d", tag, i), 32'(cv[i]), mcnt[i]);
      chk($sformatf("%s_wrapped_u%0d", tag, i), 32'(wr[i]), int'(mwr[i]));
      chk($sformatf("%s_tc_u%0d", tag, i), 32'(tc[i]), etc);
    end
  endtask

  // Rising edge, model update, compare #1 later, return on the falling edge.
  task automatic tick(input string tag);
    @(posedge Clock);
    model_edge();
    #1;
    check_all(tag);
    @(negedge Clock);
  endtask

  initial begin
    // Down sweep on MAX_VALUE=9 wrap instance.
    add(1, 0, 0, 0, 8'd0, 1, 0, 0, 1);
    for (int k = 9; k >= 0; k--)
      add(0, 0, 1, 0, 8'd0, 1, k, (k == 9), (k == 0));
    add(0, 0, 1, 0, 8'd0, 1, 9, 1, 0);
    // Saturate at 9 after loading 8.
    add(0, 1, 0, 1, 8'd8, 2, 8, 0, 0);
    add(0, 0, 1, 1, 8'd0, 2, 9, 0, 1);
    add(0, 0, 1, 1, 8'd0, 2, 9, 1, 1);
    add(0, 0, 1, 1, 8'd0, 2, 9, 1, 1);
    // Prescale 4 with an enable gap.
    add(1, 0, 0, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 1, 0, 0);
    // Clear beats Load; Load clamps to MAX_VALUE.
    add(1, 1, 1, 1, 8'd5, 1, 0, 0, 0);
    add(0, 1, 0, 1, 8'hFE, 1, 9, 0, 1);
    // Load while the prescaler sits at 2 restarts the prescale count.
    add(1, 0, 0, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 0, 0, 0);
    add(0, 1, 1, 1, 8'd3, 3, 3, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 3, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 3, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 3, 0, 0);
    add(0, 0, 1, 1, 8'd0, 3, 4, 0, 0);

    Reset = 1'b0; Enable = 1'b0; Up = 1'b1; Clear = 1'b0; Load = 1'b0;
    LoadValue = 8'd0;
    model_reset();
    @(negedge Clock);
    check_all("reset");
    Reset = 1'b1;
    tick("release");

    // Asynchronous reset in the middle of a count.
    Load = 1'b1; LoadValue = 8'h36;
    tick("pre_load");
    Load = 1'b0; Enable = 1'b1; Up = 1'b1;
    tick("pre_count");
    chk("pre_reset_value", 32'(cv[0]), 8'h37);
    Enable = 1'b0;
    #2 Reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset_value", 32'(cv[0]), 0);
    chk("async_reset_wrapped", 32'(wr[0]), 0);
    check_all("async_reset");
    #1 Reset = 1'b1;
    repeat (10) tick("hold");
    chk("hold_value", 32'(cv[0]), 0);

    // Default configuration wraps 0xFF -> 0x00.
    Clear = 1'b1;
    tick("clear");
    Clear = 1'b0; Enable = 1'b1; Up = 1'b1;
    repeat (255) tick("up");
    chk("top_value", 32'(cv[0]), 255);
    chk("top_tc", 32'(tc[0]), 1);
    chk("top_wrapped", 32'(wr[0]), 0);
    tick("wrap");
    chk("wrap_value", 32'(cv[0]), 0);
    chk("wrap_pulse", 32'(wr[0]), 1);
    tick("after_wrap");
    chk("after_wrap_value", 32'(cv[0]), 1);
    chk("after_wrap_pulse", 32'(wr[0]), 0);

    // Directed vector table.
    for (int k = 0; k < vt.size(); k++) begin
      Clear = vt[k].clr; Load = vt[k].ld; Enable = vt[k].en; Up = vt[k].up;
      LoadValue = vt[k].lv;
      tick("vec");
      chk($sformatf("vec%0d_cnt", k), 32'(cv[vt[k].inst]), vt[k].ecnt);
      chk($sformatf("vec%0d_wrapped", k), 32'(wr[vt[k].inst]), int'(vt[k].ewr));
      chk($sformatf("vec%0d_tc", k), 32'(tc[vt[k].inst]), int'(vt[k].etc));
    end

    // Randomised stimulus against the models.
    for (int k = 0; k < 1500; k++) begin
      Clear     = ($urandom_range(0, 31) == 0);
      Load      = ($urandom_range(0, 15) == 0);
      Enable    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) Up = ~Up;
      LoadValue = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_all("rand_async");
        #1 Reset = 1'b1;
      end
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
